// File: rtl/mips_pkg.sv
// Shared pipeline constants: writeback source encodings, special register
// numbers and the machine word width.
package mips_pkg;
    localparam int WORD = 32;

    localparam logic [2:0] WB_SRC_ALU = 3'd0;
    localparam logic [2:0] WB_SRC_DM  = 3'd1;
    localparam logic [2:0] WB_SRC_PC8 = 3'd2;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;
endpackage

// File: rtl/grf_wdata_mux.sv
// Writeback value selector, including the link-address adder. Also used by the
// M-stage forwarding path, so it stays free of any register-file state.
module grf_wdata_mux
    import mips_pkg::*;
#(
    parameter int WIDTH          = WORD,
    parameter int PC_LINK_OFFSET = 8
) (
    input  logic [2:0]       reg_data_op,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [WIDTH-1:0] dm_out,
    input  logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] wdata
);

    always_comb begin
        wdata = '0;
        case (reg_data_op)
            WB_SRC_ALU: wdata = alu_out;
            WB_SRC_DM:  wdata = dm_out;
            // Plain WIDTH-bit add: the link value wraps modulo 2^WIDTH.
            WB_SRC_PC8: wdata = pc + WIDTH'(PC_LINK_OFFSET);
            default:    wdata = '0;
        endcase
    end

endmodule

// File: rtl/grf_w.sv
// Writeback-stage general register file: commits the W-stage result, serves two
// D-stage read ports with same-cycle bypass, and keeps a commit trace/counter.
module grf_w
    import mips_pkg::*;
#(
    parameter int WIDTH          = WORD,
    parameter int NREG_LOG2      = 5,
    parameter int PC_LINK_OFFSET = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wb_en,
    input  logic [WIDTH-1:0]     pc_W,
    input  logic [NREG_LOG2-1:0] reg_addr,
    input  logic [2:0]           reg_data_op,
    input  logic [WIDTH-1:0]     alu_out_W,
    input  logic [WIDTH-1:0]     dm_out_W,
    input  logic [NREG_LOG2-1:0] rs_addr_D,
    input  logic [NREG_LOG2-1:0] rt_addr_D,
    output logic [WIDTH-1:0]     rs_data_D,
    output logic [WIDTH-1:0]     rt_data_D,
    output logic                 trace_valid,
    output logic [WIDTH-1:0]     trace_pc,
    output logic [NREG_LOG2-1:0] trace_addr,
    output logic [WIDTH-1:0]     trace_data,
    output logic [WIDTH-1:0]     wb_count
);

    localparam int NREG = 2 ** NREG_LOG2;

    logic [WIDTH-1:0]     regs_q [NREG];
    logic [WIDTH-1:0]     wdata;
    logic                 commit;
    logic                 trace_valid_q;
    logic [WIDTH-1:0]     trace_pc_q;
    logic [NREG_LOG2-1:0] trace_addr_q;
    logic [WIDTH-1:0]     trace_data_q;
    logic [WIDTH-1:0]     wb_count_q;
    logic [WIDTH-1:0]     wb_count_d;

    grf_wdata_mux #(
        .WIDTH          (WIDTH),
        .PC_LINK_OFFSET (PC_LINK_OFFSET)
    ) u_wdata_mux (
        .reg_data_op (reg_data_op),
        .alu_out     (alu_out_W),
        .dm_out      (dm_out_W),
        .pc          (pc_W),
        .wdata       (wdata)
    );

    // Gating with reset also suppresses the bypass, so reads are 0 during reset.
    assign commit = wb_en && (reg_addr != NREG_LOG2'(REG_ZERO)) && !reset;

    always_comb begin
        wb_count_d = wb_count_q;
        if (commit && (wb_count_q != '1)) wb_count_d = wb_count_q + WIDTH'(1);
    end

    always_comb begin
        rs_data_D = regs_q[rs_addr_D];
        if (rs_addr_D == NREG_LOG2'(REG_ZERO))     rs_data_D = '0;
        else if (commit && rs_addr_D == reg_addr)  rs_data_D = wdata;
    end

    always_comb begin
        rt_data_D = regs_q[rt_addr_D];
        if (rt_addr_D == NREG_LOG2'(REG_ZERO))     rt_data_D = '0;
        else if (commit && rt_addr_D == reg_addr)  rt_data_D = wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            trace_valid_q <= 1'b0;
            trace_pc_q    <= '0;
            trace_addr_q  <= '0;
            trace_data_q  <= '0;
            wb_count_q    <= '0;
        end else begin
            if (commit) begin
                regs_q[reg_addr] <= wdata;
                trace_pc_q       <= pc_W;
                trace_addr_q     <= reg_addr;
                trace_data_q     <= wdata;
            end
            trace_valid_q <= commit;
            wb_count_q    <= wb_count_d;
        end
    end

    assign trace_valid = trace_valid_q;
    assign trace_pc    = trace_pc_q;
    assign trace_addr  = trace_addr_q;
    assign trace_data  = trace_data_q;
    assign wb_count    = wb_count_q;

endmodule

// File: tb/tb_grf_w.sv
// Directed and random checks of grf_w against a behavioural register-file model.
module tb_grf_w;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_en;
    logic [31:0] pc_W;
    logic [4:0]  reg_addr;
    logic [2:0]  reg_data_op;
    logic [31:0] alu_out_W;
    logic [31:0] dm_out_W;
    logic [4:0]  rs_addr_D;
    logic [4:0]  rt_addr_D;
    logic [31:0] rs_data_D;
    logic [31:0] rt_data_D;
    logic        trace_valid;
    logic [31:0] trace_pc;
    logic [4:0]  trace_addr;
    logic [31:0] trace_data;
    logic [31:0] wb_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_count;
    logic        m_tvalid;
    logic [31:0] m_tpc;
    logic [4:0]  m_taddr;
    logic [31:0] m_tdata;

    grf_w dut (
        .clk         (clk),
        .reset       (reset),
        .wb_en       (wb_en),
        .pc_W        (pc_W),
        .reg_addr    (reg_addr),
        .reg_data_op (reg_data_op),
        .alu_out_W   (alu_out_W),
        .dm_out_W    (dm_out_W),
        .rs_addr_D   (rs_addr_D),
        .rt_addr_D   (rt_addr_D),
        .rs_data_D   (rs_data_D),
        .rt_data_D   (rt_data_D),
        .trace_valid (trace_valid),
        .trace_pc    (trace_pc),
        .trace_addr  (trace_addr),
        .trace_data  (trace_data),
        .wb_count    (wb_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_wdata(input logic [2:0] op, input logic [31:0] alu,
                                              input logic [31:0] dm, input logic [31:0] pc);
        logic [32:0] link;
        link = {1'b0, pc} + 33'd8;
        if (op == 3'd0) return alu;
        if (op == 3'd1) return dm;
        if (op == 3'd2) return link[31:0];
        return 32'h0;
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] a);
        logic do_commit;
        do_commit = wb_en && reg_addr != 0 && !reset;
        if (a == 0) return 32'h0;
        if (do_commit && a == reg_addr) return ref_wdata(reg_data_op, alu_out_W, dm_out_W, pc_W);
        return m_regs[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_count = 0; m_tvalid = 0; m_tpc = 0; m_taddr = 0; m_tdata = 0;
    endtask

    // One W-stage cycle: drive, check combinational reads, clock, check trace/count.
    task automatic cyc(input logic en, input logic [31:0] pc, input logic [4:0] ra,
                       input logic [2:0] op, input logic [31:0] alu, input logic [31:0] dm,
                       input logic [4:0] rs, input logic [4:0] rt);
        logic        c;
        logic [31:0] wd;
        wb_en = en; pc_W = pc; reg_addr = ra; reg_data_op = op;
        alu_out_W = alu; dm_out_W = dm; rs_addr_D = rs; rt_addr_D = rt;
        #1;
        chk("rs_read", rs_data_D, ref_read(rs));
        chk("rt_read", rt_data_D, ref_read(rt));
        c  = en && ra != 0;
        wd = ref_wdata(op, alu, dm, pc);
        @(posedge clk);
        #1;
        if (c) begin
            m_regs[ra] = wd;
            m_tpc = pc; m_taddr = ra; m_tdata = wd;
            if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
        end
        m_tvalid = c;
        chk("trace_valid", {31'h0, trace_valid}, {31'h0, m_tvalid});
        chk("trace_pc", trace_pc, m_tpc);
        chk("trace_addr", {27'h0, trace_addr}, {27'h0, m_taddr});
        chk("trace_data", trace_data, m_tdata);
        chk("wb_count", wb_count, m_count);
    endtask

    initial begin
        logic [31:0] cnt0;
        reset = 1'b1; wb_en = 0; pc_W = 0; reg_addr = 0; reg_data_op = 0;
        alu_out_W = 0; dm_out_W = 0; rs_addr_D = 7; rt_addr_D = 31;
        model_reset();
        #1;
        chk("rst_rs", rs_data_D, 32'h0);
        chk("rst_rt", rt_data_D, 32'h0);
        chk("rst_tvalid", {31'h0, trace_valid}, 32'h0);
        chk("rst_tpc", trace_pc, 32'h0);
        chk("rst_tdata", trace_data, 32'h0);
        chk("rst_count", wb_count, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // ALU commit with same-cycle bypass, then persistence
        cyc(1, 32'h100, 5'd8, 3'd0, 32'h1234, 32'h0, 5'd8, 5'd0);
        chk("alu_trace_data", trace_data, 32'h1234);
        chk("alu_count", wb_count, 32'd1);
        cyc(0, 32'h0, 5'd0, 3'd0, 32'h0, 32'h0, 5'd8, 5'd8);
        chk("alu_persist", rs_data_D, 32'h1234);

        // Link commits, including wrap past the top of the address space
        cyc(1, 32'h0000_3000, 5'd31, 3'd2, 32'h0, 32'h0, 5'd31, 5'd8);
        cyc(0, 32'h0, 5'd0, 3'd0, 32'h0, 32'h0, 5'd31, 5'd0);
        chk("link_r31", rs_data_D, 32'h0000_3008);
        cyc(1, 32'hFFFF_FFFC, 5'd31, 3'd2, 32'h0, 32'h0, 5'd31, 5'd0);
        chk("link_wrap_trace", trace_data, 32'h0000_0004);

        // Zero destination and bubble
        cnt0 = wb_count;
        cyc(1, 32'h200, 5'd0, 3'd0, 32'hDEAD, 32'h0, 5'd0, 5'd9);
        cyc(0, 32'h204, 5'd9, 3'd0, 32'hBEEF, 32'h0, 5'd0, 5'd9);
        cyc(0, 32'h0, 5'd0, 3'd0, 32'h0, 32'h0, 5'd0, 5'd9);
        chk("bubble_r9", rt_data_D, 32'h0);
        chk("bubble_count", wb_count, cnt0);

        // Load onto both ports, then an undefined source op
        cyc(1, 32'h300, 5'd3, 3'd1, 32'h1111, 32'hCAFE_BABE, 5'd3, 5'd3);
        cyc(1, 32'h304, 5'd4, 3'd5, 32'h2222, 32'h3333, 5'd3, 5'd4);
        cyc(0, 32'h0, 5'd0, 3'd0, 32'h0, 32'h0, 5'd3, 5'd4);
        chk("load_r3", rs_data_D, 32'hCAFE_BABE);
        chk("op5_r4", rt_data_D, 32'h0);

        // Back-to-back commits to r1..r4
        cnt0 = wb_count;
        for (int i = 1; i <= 4; i++)
            cyc(1, 32'h400 + 32'(i * 4), 5'(i), 3'd0, 32'hA0 + 32'(i), 32'h0, 5'(i), 5'(i - 1));
        chk("b2b_count", wb_count, cnt0 + 32'd4);

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            logic [4:0]  ra;
            logic [4:0]  rs;
            logic [31:0] pc;
            ra = 5'($urandom_range(0, 31));
            rs = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
            pc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
            cyc($urandom_range(0, 3) != 0, pc, ra, 3'($urandom_range(0, 7)), $urandom, $urandom,
                rs, 5'($urandom_range(0, 31)));
        end

        // Reset asserted over a would-be commit
        reset = 1'b1; wb_en = 1; reg_addr = 5'd5; reg_data_op = 3'd0;
        alu_out_W = 32'h5555; rs_addr_D = 5'd5; rt_addr_D = 5'd8;
        #1;
        chk("midrst_rs", rs_data_D, 32'h0);
        chk("midrst_rt", rt_data_D, 32'h0);
        chk("midrst_tvalid", {31'h0, trace_valid}, 32'h0);
        chk("midrst_count", wb_count, 32'h0);
        @(posedge clk); #1;
        chk("midrst_count2", wb_count, 32'h0);
        reset = 1'b0;
        model_reset();
        cyc(0, 32'h0, 5'd5, 3'd0, 32'h5555, 32'h0, 5'd5, 5'd8);
        chk("midrst_r5", rs_data_D, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/grf_w.md
Name: grf_w

Overview:
Writeback-stage register file. It sits directly downstream of the W-stage control decoder and consumes that decoder's reg_addr and reg_data_op outputs. The block selects the writeback value, commits it to a 32x32 general register file, and serves the two D-stage read ports with same-cycle write bypass. It also emits a registered writeback trace and a commit counter for the bench and for debug.

Parameters:
WIDTH, 32, data width of registers and datapath
NREG_LOG2, 5, register address width (2^5 = 32 registers)
PC_LINK_OFFSET, 8, offset added to pc_W for the link value

Ports:
clk  in  1  system clock, rising-edge
reset  in  1  asynchronous, active-high reset
wb_en  in  1  W-stage instruction valid; bubbles drive 0
pc_W  in  32  PC of the W-stage instruction
reg_addr  in  5  destination register from the W decoder; 0 means no write
reg_data_op  in  3  writeback source: 0 alu_out_W, 1 dm_out_W, 2 pc_W+8
alu_out_W  in  32  ALU result carried to W
dm_out_W  in  32  load data carried to W
rs_addr_D  in  5  read port A address (D stage)
rt_addr_D  in  5  read port B address (D stage)
rs_data_D  out  32  read port A data
rt_data_D  out  32  read port B data
trace_valid  out  1  registered pulse: a commit happened last cycle
trace_pc  out  32  PC of the traced commit
trace_addr  out  5  register written
trace_data  out  32  value written
wb_count  out  32  number of commits since reset

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: all 32 registers are 0. trace_valid=0, trace_pc=0, trace_addr=0, trace_data=0, wb_count=0.
- Reset dominance: reset asserted mid-operation overrides any write in that cycle. No commit, trace, or count update occurs while reset is high.
- Write data (combinational wdata):
  - reg_data_op=0 gives alu_out_W.
  - reg_data_op=1 gives dm_out_W.
  - reg_data_op=2 gives pc_W+PC_LINK_OFFSET, computed modulo 2^32 (wraps at 0xFFFFFFF8 and above).
  - reg_data_op values 3..7 give 0.
- Commit condition: commit = wb_en && reg_addr!=0. On the rising edge with commit=1, reg[reg_addr] <= wdata.
- Register 0: reads as 0 and is never written.
- Reads: combinational.
  - Address 0 returns 0.
  - Otherwise, if commit && addr==reg_addr, the port returns wdata (internal bypass, so D sees the W value in the same cycle).
  - Otherwise the port returns reg[addr].
  - Both ports obey these rules independently. rs_addr_D==rt_addr_D==reg_addr bypasses both ports.
- Trace: registered, one-cycle latency.
  - Next cycle after a commit: trace_valid=1, trace_pc=pc_W, trace_addr=reg_addr, trace_data=wdata.
  - With no commit: trace_valid=0 and the other trace fields hold their previous values.
  - Back-to-back commits keep trace_valid high continuously.
- wb_count: increments by 1 on every commit edge. Saturates at 0xFFFFFFFF and does not wrap.
- Non-committing cycles: wb_en=0, or reg_addr=0 (covers sw, beq, jr, lwie-not-taken). These leave registers, trace fields, and count unchanged and drive trace_valid=0.
- No stall input: the W stage never stalls, so a commit always completes in one cycle.

Decomposition:
- Shared package (mips_pkg) holds:
  - WB_SRC_ALU=3'd0, WB_SRC_DM=3'd1, WB_SRC_PC8=3'd2
  - REG_ZERO=5'd0, REG_RA=5'd31
  - WORD width constant
- One natural sub-module: grf_wdata_mux, the combinational reg_data_op selector including the pc+8 adder. It is shared with the forwarding-value logic in the M stage.
- Storage, bypass, trace, and counter logic stay in grf_w.

Test Plan:
- Reset: assert reset mid-simulation with wb_en=1, reg_addr=5, op=0 -> all reads 0, trace_valid=0, wb_count=0; no write lands.
- ALU commit: wb_en=1, reg_addr=8, op=0, alu=0x1234 -> same cycle rs_addr_D=8 reads 0x1234 (bypass); next cycle trace_valid=1, trace_addr=8, trace_data=0x1234, wb_count=1; reg persists afterwards.
- Link commit: op=2, pc_W=0x00003000, reg_addr=31 -> reg31=0x00003008. Then pc_W=0xFFFFFFFC -> reg31=0x00000004 (wrap).
- Zero and bubble: reg_addr=0, alu=0xDEAD, wb_en=1; then wb_en=0, reg_addr=9 -> reads of r0 and r9 return 0, trace_valid=0, wb_count unchanged.
- Dual-port and load: op=1, dm=0xCAFEBABE, reg_addr=3, rs_addr_D=rt_addr_D=3 -> both ports return 0xCAFEBABE same cycle. Then op=5 with reg_addr=4 -> reg4=0.
- Back-to-back commits: four consecutive commits to regs 1..4 -> trace_valid high for 4 cycles, wb_count=4, trace fields track each commit in order.
